// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR): one power-of-two mux stage per register, valid/ready handshake.
// Define SHIFTER_CARRY_OUT_EN to add the registered out_carry output (last bit shifted out).
module shifter_pipe #(
  parameter  int WIDTH = 32,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_CARRY_OUT_EN
  ,
  output logic             out_carry
`endif
);

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  // Stage registers; index k holds the result of the 2^k mux stage.
  logic [WIDTH-1:0] q_data  [LOG2W];
  shift_op_e        q_op    [LOG2W];
  logic [LOG2W-1:0] q_shamt [LOG2W];
  logic             q_valid [LOG2W];

  // Inputs to each stage (stage 0 from the ports, others from the previous register).
  logic [WIDTH-1:0] src_data  [LOG2W];
  shift_op_e        src_op    [LOG2W];
  logic [LOG2W-1:0] src_shamt [LOG2W];
  logic             src_valid [LOG2W];
  logic [WIDTH-1:0] nxt_data  [LOG2W];

`ifdef SHIFTER_CARRY_OUT_EN
  logic q_carry   [LOG2W];
  logic src_carry [LOG2W];
  logic nxt_carry [LOG2W];
`endif

  logic stall;

  function automatic logic [WIDTH-1:0] shift_data(input logic [WIDTH-1:0] d,
                                                  input shift_op_e op,
                                                  input int unsigned amt);
    case (op)
      OP_LSL:  shift_data = d << amt;
      OP_LSR:  shift_data = d >> amt;
      OP_ASR:  shift_data = $signed(d) >>> amt;
      OP_ROR:  shift_data = (d >> amt) | (d << (WIDTH - amt));
      default: shift_data = d;
    endcase
  endfunction

`ifdef SHIFTER_CARRY_OUT_EN
  // Last bit leaving this stage: d[WIDTH-amt] for LSL, d[amt-1] otherwise (ROR wraps it to the MSB).
  function automatic logic shift_carry(input logic [WIDTH-1:0] d,
                                       input shift_op_e op,
                                       input int unsigned amt);
    logic [WIDTH-1:0] t;
    t = (op == OP_LSL) ? (d >> (WIDTH - amt)) : (d >> (amt - 1));
    return t[0];
  endfunction
`endif

  assign out_valid = q_valid[LOG2W-1];
  assign out_data  = q_data[LOG2W-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
`ifdef SHIFTER_CARRY_OUT_EN
  assign out_carry = q_carry[LOG2W-1];
`endif

  // NOTE: every element of every always_comb output is assigned on every pass, so no latches are inferred.
  always_comb begin
    src_data[0]  = in_data;
    src_op[0]    = shift_op_e'(in_op);
    src_shamt[0] = in_shamt;
    src_valid[0] = in_valid && in_ready;
`ifdef SHIFTER_CARRY_OUT_EN
    src_carry[0] = 1'b0;
`endif
    for (int k = 1; k < LOG2W; k++) begin
      src_data[k]  = q_data[k-1];
      src_op[k]    = q_op[k-1];
      src_shamt[k] = q_shamt[k-1];
      src_valid[k] = q_valid[k-1];
`ifdef SHIFTER_CARRY_OUT_EN
      src_carry[k] = q_carry[k-1];
`endif
    end
    for (int k = 0; k < LOG2W; k++) begin
      nxt_data[k] = src_shamt[k][k] ? shift_data(src_data[k], src_op[k], 1 << k) : src_data[k];
`ifdef SHIFTER_CARRY_OUT_EN
      nxt_carry[k] = src_shamt[k][k] ? shift_carry(src_data[k], src_op[k], 1 << k) : src_carry[k];
`endif
    end
  end

  // NOTE: the stage arrays are a handful of flops, not RAM, so clearing them all on reset is cheap and keeps out_data at 0.
  // NOTE: non-blocking assignments here so every stage samples the previous stage's old value on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LOG2W; k++) begin
        q_data[k]  <= '0;
        q_op[k]    <= OP_LSL;
        q_shamt[k] <= '0;
        q_valid[k] <= 1'b0;
`ifdef SHIFTER_CARRY_OUT_EN
        q_carry[k] <= 1'b0;
`endif
      end
    end else if (!stall) begin
      // The whole pipe, bubbles included, advances together or not at all.
      for (int k = 0; k < LOG2W; k++) begin
        q_data[k]  <= nxt_data[k];
        q_op[k]    <= src_op[k];
        q_shamt[k] <= src_shamt[k];
        q_valid[k] <= src_valid[k];
`ifdef SHIFTER_CARRY_OUT_EN
        q_carry[k] <= nxt_carry[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed self-checking bench for shifter_pipe at WIDTH=8 (3-stage pipe).
module tb_shifter_pipe;
  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [2:0] in_shamt;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef SHIFTER_CARRY_OUT_EN
  logic       out_carry;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

  shifter_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_shamt  (in_shamt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFTER_CARRY_OUT_EN
    ,
    .out_carry (out_carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_carry(input string tag, input logic exp);
`ifdef SHIFTER_CARRY_OUT_EN
    check({tag, " carry"}, {31'b0, out_carry}, {31'b0, exp});
`endif
  endtask

  // One isolated transaction: measures latency in edges counted from the accepting edge.
  task automatic single(input string tag, input logic [1:0] op, input logic [2:0] sh,
                        input logic [7:0] d, input logic [7:0] exp, input logic expc);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_shamt = sh; in_data = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 32'd3);
    check({tag, " data"}, {24'b0, out_data}, {24'b0, exp});
    check_carry(tag, expc);
  endtask

  logic [7:0] ror_exp [8];
  logic [7:0] bp_exp  [3];

  initial begin
    ror_exp = '{8'h96, 8'h4B, 8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D};
    bp_exp  = '{8'h78, 8'h3C, 8'h1E};

    reset = 1'b1; in_valid = 1'b0; in_op = LSL; in_shamt = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset out_data", {24'b0, out_data}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check_carry("reset", 1'b0);
    reset = 1'b0;

    // Mode coverage on 0x96 by 3, shamt=0 in every mode, and the shamt=WIDTH-1 corner.
    single("asr96_3", ASR, 3'd3, 8'h96, 8'hF2, 1'b1);
    single("lsr96_3", LSR, 3'd3, 8'h96, 8'h12, 1'b1);
    single("lsl96_3", LSL, 3'd3, 8'h96, 8'hB0, 1'b0);
    single("ror96_3", ROR, 3'd3, 8'h96, 8'hD2, 1'b1);
    single("lsl96_0", LSL, 3'd0, 8'h96, 8'h96, 1'b0);
    single("lsr96_0", LSR, 3'd0, 8'h96, 8'h96, 1'b0);
    single("asr96_0", ASR, 3'd0, 8'h96, 8'h96, 1'b0);
    single("ror96_0", ROR, 3'd0, 8'h96, 8'h96, 1'b0);
    single("asr80_7", ASR, 3'd7, 8'h80, 8'hFF, 1'b0);
    single("lsr80_7", LSR, 3'd7, 8'h80, 8'h01, 1'b0);
    single("ror01_7", ROR, 3'd7, 8'h01, 8'h02, 1'b0);
    single("lslFF_7", LSL, 3'd7, 8'hFF, 8'h80, 1'b1);
    single("asr7F_5", ASR, 3'd5, 8'h7F, 8'h03, 1'b1);

    // Back-to-back: item j (ROR 0x96 by j) is accepted on edge j and seen before edge j+3.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 8) begin
        check($sformatf("b2b in_ready %0d", c), {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_op = ROR; in_shamt = 3'(c); in_data = 8'h96;
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 3 && c < 11) begin
        check($sformatf("b2b valid %0d", c - 3), {31'b0, out_valid}, 32'd1);
        check($sformatf("b2b data %0d", c - 3), {24'b0, out_data}, {24'b0, ror_exp[c-3]});
      end else begin
        check($sformatf("b2b idle %0d", c), {31'b0, out_valid}, 32'd0);
      end
      @(posedge clk);
    end

    // Backpressure: three LSR 0xF0 items fill the pipe, then 5 stalled cycles.
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = 1'b1; in_op = LSR; in_shamt = 3'(c + 1); in_data = 8'hF0;
      @(posedge clk);
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      // A pending input must not be taken while stalled.
      in_valid = 1'b1; in_op = LSL; in_shamt = 3'd0; in_data = 8'hAA;
      check($sformatf("stall valid %0d", s), {31'b0, out_valid}, 32'd1);
      check($sformatf("stall data %0d", s), {24'b0, out_data}, 32'h78);
      check($sformatf("stall in_ready %0d", s), {31'b0, in_ready}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 6; d++) begin
      if (d > 0) @(negedge clk);
      if (d < 3) begin
        check($sformatf("drain valid %0d", d), {31'b0, out_valid}, 32'd1);
        check($sformatf("drain data %0d", d), {24'b0, out_data}, {24'b0, bp_exp[d]});
      end else begin
        check($sformatf("drain empty %0d", d), {31'b0, out_valid}, 32'd0);
      end
      @(posedge clk);
    end

    // Reset with two items in flight: neither may ever come out.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = LSL; in_shamt = 3'd1; in_data = 8'h55;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset out_data", {24'b0, out_data}, 32'd0);
    check("midreset in_ready", {31'b0, in_ready}, 32'd1);
    check_carry("midreset", 1'b0);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("postreset idle %0d", c), {31'b0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter. Successor to the fixed 8-bit, 2-bit-shamt combinational shifters in the shifter library.
- Supports four shift modes selected per transaction: LSL, LSR, ASR and ROR.
- Builds one log2 mux stage per pipeline register. Uses a valid/ready handshake so it sits directly between ALU operand fetch and writeback.

Parameters:
- WIDTH, 32, data width. Power of two, at least 4.
- LOG2W, $clog2(WIDTH), shift-amount width and pipeline depth. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input transaction present
- in_ready  output  1  block can accept an input this cycle
- in_op  input  2  mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR
- in_shamt  input  LOG2W  shift amount, 0..WIDTH-1
- in_data  input  WIDTH  operand
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result
- out_data  output  WIDTH  shifted result
- out_carry  output  1  last bit shifted out (only with SHIFTER_CARRY_OUT_EN)

Behaviour:
- Single clock domain. Reset is synchronous and active-high; only the one clock and the one reset exist.
- Pipeline: LOG2W stages. Stage k (k=0..LOG2W-1) shifts by 2^k when shamt bit k=1, else passes data through. Stage registers hold data, op, shamt, valid and carry.
- Modes:
  - LSL fills with 0 from the LSB.
  - LSR fills with 0 from the MSB.
  - ASR fills with the original data[WIDTH-1] at every stage (sign preserved across all stages).
  - ROR wraps bits shifted out of the LSB into the MSB.
- Handshake:
  - Input accepted on clk edge when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall.
  - While stalled, every stage register holds, including bubbles. No partial advance.
- When not stalled, all stages advance every cycle. Stage 0 loads in_valid&&in_ready as its valid bit.
- Latency: exactly LOG2W cycles from the accepting edge to out_valid high, when there is no stall. For WIDTH=8 this is 3 cycles.
- Throughput: one result per cycle when out_ready is held high.
- Bubbles propagate as valid=0. Data of invalid stages is don't-care internally, but out_data must not change while out_valid=1 and stalled.
- Boundary conditions:
  - shamt=0 returns in_data unchanged in every mode; out_carry=0.
  - shamt=WIDTH-1 is the maximum. ASR of a negative operand by WIDTH-1 yields all ones.
  - Simultaneous input accept and output consume in the same cycle is legal when out_ready=1.
- Reset (any time, including mid-operation):
  - Next edge clears all stage valid bits, data, op, shamt and carry to 0.
  - Outputs after reset: out_valid=0, out_data=0, out_carry=0, in_ready=1.
  - In-flight transactions are discarded and never appear at the output.
- out_data and out_valid are driven directly from the last stage register. No combinational path from in_* to out_*.
- in_ready is combinational from out_valid and out_ready only.

Optional Feature:
- Macro: SHIFTER_CARRY_OUT_EN.
- Defined: out_carry port exists and is registered alongside out_data. Value is the last bit shifted out:
  - LSL: in_data[WIDTH-shamt]
  - LSR/ASR: in_data[shamt-1]
  - ROR: result[WIDTH-1]
  - shamt=0: 0
  - Each stage updates the carry only when its shamt bit is 1.
- Not defined: out_carry port and all carry registers are absent. Data path and timing are identical.

Test Plan (WIDTH=8, LOG2W=3):
- ASR in_data=0x96, shamt=3, out_ready=1 -> out_valid 3 cycles after accept, out_data=0xF2, out_carry=1.
- LSR 0x96 by 3 -> 0x12, carry=1. LSL 0x96 by 3 -> 0xB0, carry=0. ROR 0x96 by 3 -> 0xD2, carry=1. shamt=0, any op -> 0x96, carry=0.
- Back-to-back: 8 consecutive inputs with out_ready=1 -> 8 results on 8 consecutive cycles, in order, in_ready never low.
- Backpressure: out_ready=0 for 5 cycles with 3 items in flight -> out_data stable, in_ready=0, no item lost or duplicated; results drain in order after out_ready=1.
- Reset mid-operation: assert reset with 2 items in flight -> next cycle out_valid=0, out_data=0, in_ready=1; neither item ever emitted.
- ASR 0x80 by 7 -> 0xFF; LSR 0x80 by 7 -> 0x01; ROR 0x01 by 7 -> 0x02.
